// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR random-number source.
//   rng_state_e : draw FSM states (IDLE / DRAW / HOLD)
//   DEF_TAPS    : default Galois feedback mask, x^16+x^14+x^13+x^11+1
//   DEF_SEED    : default reset / zero-substitute seed
//   tries_w()   : width of the per-draw rejection counter
// No ports; imported by lfsr_core and lfsr_rng.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } rng_state_e;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    // Counter holds 0 .. max_tries-1; never narrower than one bit.
    function automatic int tries_w(input int max_tries);
        return (max_tries <= 1) ? 1 : $clog2(max_tries);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seed load and zero-seed substitution.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (state=SEED, lockup=0)
//   step       in   advance the LFSR one position this cycle
//   seed_load  in   load seed_value (takes priority over step)
//   seed_value in   WIDTH seed; zero is replaced by SEED
//   state      out  WIDTH current LFSR state
//   lockup     out  sticky flag: a zero seed was substituted
module lfsr_core
    import rng_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= SEED;
            lockup <= 1'b0;
        end else if (seed_load) begin
            // An all-zero state would freeze the LFSR forever.
            if (seed_value == '0) begin
                state  <= SEED;
                lockup <= 1'b1;
            end else begin
                state  <= seed_value;
            end
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Bounded random-number source: Galois LFSR plus a req/valid/ready draw FSM
// that returns uniform values in [0, RANGE-1] by rejection sampling.
// Optional feature macro: RNG_NO_REPEAT_EN -- also rejects a candidate equal
// to the previously delivered value (the fallback value may still repeat).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   enable     in   free-run LFSR advance while IDLE/HOLD
//   seed_load  in   load seed_value into the LFSR
//   seed_value in   WIDTH seed; zero replaced by SEED
//   rd_req     in   request one draw (sampled in IDLE only)
//   rnd_valid  out  rnd_num valid; held until rnd_ready
//   rnd_ready  in   consumer accepts rnd_num
//   rnd_num    out  OUT_W drawn value, < RANGE
//   lockup     out  sticky zero-seed substitution flag
//   lfsr_state out  WIDTH current LFSR state
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED      = DEF_SEED,
    parameter int               OUT_W     = 4,
    parameter int               RANGE     = 10,
    parameter int               MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic             rd_req,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [OUT_W-1:0] rnd_num,
    output logic             lockup,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int               TW       = tries_w(MAX_TRIES);
    localparam logic [TW-1:0]    LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] RANGE_N  = RANGE_X[OUT_W-1:0];

    if (WIDTH < 4 || WIDTH < OUT_W) begin : g_bad_width
        $error("lfsr_rng: WIDTH must be >= 4 and >= OUT_W");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_rng: SEED must be nonzero");
    end
    if (RANGE <= (1 << (OUT_W - 1)) || RANGE > (1 << OUT_W)) begin : g_bad_range
        $error("lfsr_rng: RANGE must satisfy 2^(OUT_W-1) < RANGE <= 2^OUT_W");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("lfsr_rng: MAX_TRIES must be >= 1");
    end

    rng_state_e       state_q, state_d;
    logic [TW-1:0]    tries_q;
    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic             accept;
    logic             last_try;
    logic             step;
    logic [OUT_W-1:0] fallback;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .state      (lfsr_state),
        .lockup     (lockup)
    );

    // Candidate is the pre-step state of this cycle.
    assign cand     = lfsr_state[OUT_W-1:0];
    assign in_range = ({1'b0, cand} < RANGE_X);
    assign last_try = (tries_q == LAST_TRY);
    // RANGE > 2^(OUT_W-1) guarantees cand-RANGE < RANGE for out-of-range
    // candidates; an in-range candidate that was rejected only as a repeat
    // is delivered unchanged.
    assign fallback = in_range ? cand : (cand - RANGE_N);

`ifdef RNG_NO_REPEAT_EN
    logic [OUT_W-1:0] last_num;
    logic             hist_vld;

    assign accept = in_range && !(hist_vld && (cand == last_num));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_num <= '0;
            hist_vld <= 1'b0;
        end else if (state_q == HOLD && rnd_ready) begin
            last_num <= rnd_num;
            hist_vld <= 1'b1;
        end
    end
`else
    assign accept = in_range;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_req) state_d = DRAW;
            DRAW:    if (accept || last_try) state_d = HOLD;
            HOLD:    if (rnd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        rnd_valid = (state_q == HOLD);
        step      = enable || (state_q == DRAW);
    end

    // Tries counter and delivered value
    always_ff @(posedge clk) begin
        if (reset) begin
            tries_q <= '0;
            rnd_num <= '0;
        end else begin
            case (state_q)
                IDLE: if (rd_req) tries_q <= '0;
                DRAW: begin
                    if (accept) begin
                        rnd_num <= cand;
                    end else if (last_try) begin
                        rnd_num <= fallback;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_value;
    logic        rd_req;
    logic        rnd_ready;

    logic        rnd_valid,  rnd_valid1;
    logic [3:0]  rnd_num,    rnd_num1;
    logic        lockup,     lockup1;
    logic [15:0] lfsr_state, lfsr_state1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_rng u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .rd_req     (rd_req),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_num    (rnd_num),
        .lockup     (lockup),
        .lfsr_state (lfsr_state)
    );

    lfsr_rng #(.MAX_TRIES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .rd_req     (rd_req),
        .rnd_valid  (rnd_valid1),
        .rnd_ready  (rnd_ready),
        .rnd_num    (rnd_num1),
        .lockup     (lockup1),
        .lfsr_state (lfsr_state1)
    );

    typedef struct {
        logic        en;
        logic        sl;
        logic [15:0] sv;
        logic        req;
        logic        rdy;
        logic [15:0] st;
        logic        v;
        logic [3:0]  n;
        logic        lk;
        logic        v1;
        logic [3:0]  n1;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable     = 1'b0;
        seed_load  = 1'b0;
        seed_value = 16'h0;
        rd_req     = 1'b0;
        rnd_ready  = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!rnd_valid && n < max_cycles) begin
            cyc();
            n++;
        end
        checks++;
        if (!rnd_valid) begin
            errors++;
            $display("FAIL %s: rnd_valid not seen within %0d cycles", name, max_cycles);
        end
    endtask

    initial begin
        // en sl seed     req rdy state     v  n  lk  v1 n1
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hE270, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 16'hACE1, 1'b0, 1'b0, 16'hACE1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hACE1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hE270, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hE270, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hE270, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hE270, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 16'h000F, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hB407, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hEE03, 1'b1, 4'd7, 1'b0, 1'b1, 4'd5};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hEE03, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hACE1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hE270, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0};

        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        check("reset_state",  lfsr_state, 16'hACE1);
        check("reset_valid",  rnd_valid,  1'b0);
        check("reset_num",    rnd_num,    4'd0);
        check("reset_lockup", lockup,     1'b0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            enable     = tbl[i].en;
            seed_load  = tbl[i].sl;
            seed_value = tbl[i].sv;
            rd_req     = tbl[i].req;
            rnd_ready  = tbl[i].rdy;
            cyc();
            check($sformatf("vec%0d_state", i),  lfsr_state, tbl[i].st);
            check($sformatf("vec%0d_valid", i),  rnd_valid,  tbl[i].v);
            if (tbl[i].v) check($sformatf("vec%0d_num", i), rnd_num, tbl[i].n);
            check($sformatf("vec%0d_lockup", i), lockup,     tbl[i].lk);
            check($sformatf("vec%0d_valid1", i), rnd_valid1, tbl[i].v1);
            if (tbl[i].v1) check($sformatf("vec%0d_num1", i), rnd_num1, tbl[i].n1);
        end

        // Reseed during DRAW overrides the step; reseed during HOLD keeps the result.
        idle_inputs();
        seed_load = 1'b1; seed_value = 16'h000F;
        cyc();
        idle_inputs();
        rd_req = 1'b1;
        cyc();
        idle_inputs();
        seed_load = 1'b1; seed_value = 16'hACE1;
        cyc();
        check("draw_reseed_state", lfsr_state, 16'hACE1);
        check("draw_reseed_valid", rnd_valid,  1'b0);
        idle_inputs();
        cyc();
        check("draw_reseed_valid2", rnd_valid,  1'b1);
        check("draw_reseed_num",    rnd_num,    4'd1);
        check("draw_reseed_step",   lfsr_state, 16'hE270);
        seed_load = 1'b1; seed_value = 16'h000F;
        cyc();
        check("hold_reseed_state", lfsr_state, 16'h000F);
        check("hold_reseed_valid", rnd_valid,  1'b1);
        check("hold_reseed_num",   rnd_num,    4'd1);
        idle_inputs();
        rnd_ready = 1'b1;
        cyc();
        check("hold_release", rnd_valid, 1'b0);

        // Repeat suppression: the same seed twice yields 1, then 0 if history is enabled.
        idle_inputs();
        seed_load = 1'b1; seed_value = 16'hACE1;
        cyc();
        idle_inputs();
        rd_req = 1'b1;
        cyc();
        idle_inputs();
        wait_valid("rep_first_wait", 20);
        check("rep_first_num", rnd_num, 4'd1);
        rnd_ready = 1'b1;
        cyc();
        idle_inputs();
        seed_load = 1'b1; seed_value = 16'hACE1;
        cyc();
        idle_inputs();
        rd_req = 1'b1;
        cyc();
        idle_inputs();
        wait_valid("rep_second_wait", 20);
`ifdef RNG_NO_REPEAT_EN
        check("rep_second_num", rnd_num, 4'd0);
`else
        check("rep_second_num", rnd_num, 4'd1);
`endif
        rnd_ready = 1'b1;
        cyc();
        idle_inputs();

        // Reset in the middle of a draw discards it and clears lockup.
        seed_load = 1'b1; seed_value = 16'h0000;
        cyc();
        check("lockup_set", lockup, 1'b1);
        idle_inputs();
        seed_load = 1'b1; seed_value = 16'h000F;
        cyc();
        idle_inputs();
        rd_req = 1'b1;
        cyc();
        idle_inputs();
        reset = 1'b1;
        cyc();
        check("mid_reset_state",  lfsr_state, 16'hACE1);
        check("mid_reset_valid",  rnd_valid,  1'b0);
        check("mid_reset_lockup", lockup,     1'b0);
        reset = 1'b0;
        cyc();
        cyc();
        check("post_reset_valid", rnd_valid,  1'b0);
        check("post_reset_state", lfsr_state, 16'hACE1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
